ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the five-stage MIPS pipeline, directly downstream of the ALU-control decoder.
- Consumes the 3-bit ALU control code plus ID/EX operands, applies operand forwarding, and performs the ALU operation.
- Captures result, flags and pass-through control into the EX/MEM pipeline register.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- DATA_W, 32, datapath width for operands and result
- REG_ADDR_W, 5, destination register address width

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold EX/MEM register contents
- flush  in  1  load a bubble into EX/MEM
- id_valid  in  1  ID/EX slot holds a real instruction
- id_alu_control  in  3  operation code from ALU-control decoder
- id_alu_src  in  1  0: operand B from rt path, 1: from id_imm
- id_rs_data  in  DATA_W  rs register-file value
- id_rt_data  in  DATA_W  rt register-file value
- id_imm  in  DATA_W  immediate, already sign-extended
- id_rd_addr  in  REG_ADDR_W  destination register
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits carried forward
- fwd_a, fwd_b  in  2 each  forwarding selects for rs / rt paths
- wb_fwd_data  in  DATA_W  MEM/WB write-back value
- ex_valid  out  1  EX/MEM slot valid
- ex_alu_result  out  DATA_W  registered ALU result
- ex_zero  out  1  registered result==0
- ex_overflow  out  1  registered signed overflow (add/sub only)
- ex_store_data  out  DATA_W  forwarded rt value for stores
- ex_rd_addr  out  REG_ADDR_W  registered destination
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered control

Behaviour:
- Reset: async on rst_n low; every output and internal register is 0 and stays 0 while rst_n is low. Release is synchronous to the next clk edge.
- Forwarding mux, applied separately to rs and rt:
  - 00: register value
  - 10: ex_alu_result, the current EX/MEM register
  - 01: wb_fwd_data
  - 11: register value (reserved)
- Operand A is forwarded rs. Operand B is forwarded rt when id_alu_src=0, id_imm when id_alu_src=1. ex_store_data always takes forwarded rt, never imm.
- ALU is combinational, wrapping modulo 2^DATA_W:
  - 010: A+B
  - 110: A-B
  - 000: A&B
  - 001: A|B
  - 111: signed A<B gives result 1, otherwise 0
  - 011, 100, 101: result 0
- Overflow: computed for 010 and 110 only.
  - add: sign(A)==sign(B) and sign(result)!=sign(A)
  - sub: sign(A)!=sign(B) and sign(result)!=sign(A)
  - all other ops: 0
  - Overflow does not suppress reg_write.
- zero = (result==0), including for slt and undefined codes.
- Latency: one cycle. Inputs sampled at edge N appear on ex_* after edge N.
- Edge priority, highest first: reset > flush > stall > load.
  - flush: ex_valid and all four control outputs become 0; data outputs (result, store_data, rd_addr, zero, overflow) become 0. Flush with stall asserted still inserts a bubble.
  - stall (no flush): all ex_* outputs hold their value.
  - load with id_valid=0: bubble, identical to flush.
  - load with id_valid=1: ex_valid=1; all fields take the computed and pass-through values.
- Stall with fwd select 10: operand comes from the held ex_alu_result; no feedback loop beyond one register.
- No other state; no handshake beyond stall/flush.

Test Plan:
- Reset mid-operation: drive valid add, assert rst_n low between edges -> all ex_* are 0 immediately, with no clock edge needed.
- Arithmetic: 010 with A=0x7FFFFFFF, B=1 -> ex_alu_result=0x80000000, ex_overflow=1. 110 with A=B=5 -> result 0, ex_zero=1, overflow=0.
- Logic and slt: 000 A=0xF0F0, B=0xFF00 -> 0xF000. 001 gives 0xFFF0. 111 A=0xFFFFFFFF (-1), B=1 -> 1. 111 A=1, B=0xFFFFFFFF -> 0.
- Forwarding: cycle 1 add 3+4 (result 7), cycle 2 fwd_a=10, id_alu_src=1, imm=1 -> 8. Then fwd_b=01, wb_fwd_data=0x20, id_alu_src=0, op 001 -> A|0x20. ex_store_data=0x20.
- Stall/flush: load valid sw (mem_write=1); assert stall 3 cycles with changing inputs -> outputs frozen. Assert stall and flush together -> ex_valid=0, ex_mem_write=0.
- Bubble: id_valid=0 with reg_write=1 presented -> ex_valid=0, ex_reg_write=0, ex_alu_result=0.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of the five-stage MIPS pipeline: operand forwarding, ALU and
// the EX/MEM pipeline register with stall (hold) and flush (bubble) control.
module ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [2:0]            id_alu_control,
  input  logic                  id_alu_src,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic [1:0]            fwd_a,
  input  logic [1:0]            fwd_b,
  input  logic [DATA_W-1:0]     wb_fwd_data,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_alu_result,
  output logic                  ex_zero,
  output logic                  ex_overflow,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg
);

  localparam int MSB = DATA_W - 1;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Whole EX/MEM payload; an all-zero value is a bubble.
  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  zero;
    logic                  overflow;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     store_data;
  } ex_mem_t;

  ex_mem_t ex_mem_q;
  ex_mem_t ex_mem_d;

  // Select 11 is reserved and falls back to the register-file value.
  function automatic logic [DATA_W-1:0] fwd_mux(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] reg_val,
    input logic [DATA_W-1:0] mem_val,
    input logic [DATA_W-1:0] wb_val
  );
    case (sel)
      FWD_MEM: fwd_mux = mem_val;
      FWD_WB:  fwd_mux = wb_val;
      FWD_REG: fwd_mux = reg_val;
      default: fwd_mux = reg_val;
    endcase
  endfunction

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] rt_fwd;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] alu_result;
  logic              alu_overflow;
  logic              slt;

  // The EX/MEM forward path reads the registered result only, so a stalled
  // stage simply re-presents the held value without a combinational loop.
  assign op_a   = fwd_mux(fwd_a, id_rs_data, ex_mem_q.alu_result, wb_fwd_data);
  assign rt_fwd = fwd_mux(fwd_b, id_rt_data, ex_mem_q.alu_result, wb_fwd_data);
  assign op_b   = id_alu_src ? id_imm : rt_fwd;

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;
  assign slt  = $signed(op_a) < $signed(op_b);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and infers a latch.
    alu_result   = '0;
    alu_overflow = 1'b0;
    case (id_alu_control)
      ALU_ADD: begin
        alu_result   = sum;
        alu_overflow = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
      end
      ALU_SUB: begin
        alu_result   = diff;
        alu_overflow = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
      end
      ALU_AND: alu_result = op_a & op_b;
      ALU_OR:  alu_result = op_a | op_b;
      ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, slt};
      default: alu_result = '0;
    endcase
  end

  // Flush wins over stall; an invalid ID/EX slot loads the same bubble.
  always_comb begin
    ex_mem_d = ex_mem_q;
    if (flush) begin
      ex_mem_d = '0;
    end else if (stall) begin
      ex_mem_d = ex_mem_q;
    end else if (!id_valid) begin
      ex_mem_d = '0;
    end else begin
      ex_mem_d.valid      = 1'b1;
      ex_mem_d.reg_write  = id_reg_write;
      ex_mem_d.mem_read   = id_mem_read;
      ex_mem_d.mem_write  = id_mem_write;
      ex_mem_d.mem_to_reg = id_mem_to_reg;
      ex_mem_d.rd_addr    = id_rd_addr;
      ex_mem_d.zero       = (alu_result == '0);
      ex_mem_d.overflow   = alu_overflow;
      ex_mem_d.alu_result = alu_result;
      ex_mem_d.store_data = rt_fwd;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs; the whole payload is reset because outputs
  // must read as zero the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
    end
  end

  assign ex_valid      = ex_mem_q.valid;
  assign ex_alu_result = ex_mem_q.alu_result;
  assign ex_zero       = ex_mem_q.zero;
  assign ex_overflow   = ex_mem_q.overflow;
  assign ex_store_data = ex_mem_q.store_data;
  assign ex_rd_addr    = ex_mem_q.rd_addr;
  assign ex_reg_write  = ex_mem_q.reg_write;
  assign ex_mem_read   = ex_mem_q.mem_read;
  assign ex_mem_write  = ex_mem_q.mem_write;
  assign ex_mem_to_reg = ex_mem_q.mem_to_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU ops, flags, forwarding,
// stall/flush priority, bubbles and asynchronous reset.
module tb_ex_stage;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  logic                  clk;
  logic                  rst_n;
  logic                  stall;
  logic                  flush;
  logic                  id_valid;
  logic [2:0]            id_alu_control;
  logic                  id_alu_src;
  logic [DATA_W-1:0]     id_rs_data;
  logic [DATA_W-1:0]     id_rt_data;
  logic [DATA_W-1:0]     id_imm;
  logic [REG_ADDR_W-1:0] id_rd_addr;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_mem_write;
  logic                  id_mem_to_reg;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic [DATA_W-1:0]     wb_fwd_data;
  logic                  ex_valid;
  logic [DATA_W-1:0]     ex_alu_result;
  logic                  ex_zero;
  logic                  ex_overflow;
  logic [DATA_W-1:0]     ex_store_data;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic                  ex_mem_to_reg;

  int checks = 0;
  int errors = 0;

  ex_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_alu_control(id_alu_control), .id_alu_src(id_alu_src),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_zero(ex_zero),
    .ex_overflow(ex_overflow), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " valid"},      ex_valid,      0);
    check({tag, " result"},     ex_alu_result, 0);
    check({tag, " zero"},       ex_zero,       0);
    check({tag, " overflow"},   ex_overflow,   0);
    check({tag, " store"},      ex_store_data, 0);
    check({tag, " rd"},         ex_rd_addr,    0);
    check({tag, " reg_write"},  ex_reg_write,  0);
    check({tag, " mem_read"},   ex_mem_read,   0);
    check({tag, " mem_write"},  ex_mem_write,  0);
    check({tag, " mem_to_reg"}, ex_mem_to_reg, 0);
  endtask

  // Present a valid register-register op with no forwarding.
  task automatic set_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    id_valid       = 1'b1;
    id_alu_control = op;
    id_rs_data     = a;
    id_rt_data     = b;
    id_alu_src     = 1'b0;
    id_imm         = 32'h0;
    fwd_a          = 2'b00;
    fwd_b          = 2'b00;
    id_reg_write   = 1'b1;
    id_mem_read    = 1'b0;
    id_mem_write   = 1'b0;
    id_mem_to_reg  = 1'b0;
    id_rd_addr     = 5'd3;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs sampled likewise.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_alu_control = 3'b000; id_alu_src = 1'b0; id_rs_data = '0; id_rt_data = '0;
    id_imm = '0; id_rd_addr = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    id_mem_write = 1'b0; id_mem_to_reg = 1'b0; fwd_a = 2'b00; fwd_b = 2'b00;
    wb_fwd_data = '0;

    repeat (2) step();
    check_all_zero("reset");
    rst_n = 1'b1;

    // Signed add overflow.
    set_op(3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
    step();
    check("add_ovf result", ex_alu_result, 32'h8000_0000);
    check("add_ovf overflow", ex_overflow, 1);
    check("add_ovf zero", ex_zero, 0);
    check("add_ovf valid", ex_valid, 1);
    check("add_ovf rd", ex_rd_addr, 5'd3);
    check("add_ovf reg_write", ex_reg_write, 1);

    set_op(3'b110, 32'd5, 32'd5);
    step();
    check("sub_eq result", ex_alu_result, 32'h0);
    check("sub_eq zero", ex_zero, 1);
    check("sub_eq overflow", ex_overflow, 0);

    // Subtract overflow: most-negative minus one.
    set_op(3'b110, 32'h8000_0000, 32'h0000_0001);
    step();
    check("sub_ovf result", ex_alu_result, 32'h7FFF_FFFF);
    check("sub_ovf overflow", ex_overflow, 1);

    set_op(3'b000, 32'h0000_F0F0, 32'h0000_FF00);
    step();
    check("and result", ex_alu_result, 32'h0000_F000);
    check("and overflow", ex_overflow, 0);

    set_op(3'b001, 32'h0000_F0F0, 32'h0000_FF00);
    step();
    check("or result", ex_alu_result, 32'h0000_FFF0);

    set_op(3'b111, 32'hFFFF_FFFF, 32'h0000_0001);
    step();
    check("slt_neg result", ex_alu_result, 32'h1);
    check("slt_neg zero", ex_zero, 0);

    set_op(3'b111, 32'h0000_0001, 32'hFFFF_FFFF);
    step();
    check("slt_pos result", ex_alu_result, 32'h0);
    check("slt_pos zero", ex_zero, 1);

    set_op(3'b101, 32'd9, 32'd9);
    step();
    check("undef result", ex_alu_result, 32'h0);
    check("undef zero", ex_zero, 1);
    check("undef valid", ex_valid, 1);

    // Forwarding chain: 3+4, then EX/MEM result + imm 1, then OR with WB value.
    set_op(3'b010, 32'd3, 32'd4);
    step();
    check("fwd base result", ex_alu_result, 32'd7);
    set_op(3'b010, 32'hDEAD_0000, 32'h0000_BEEF);
    fwd_a = 2'b10; id_alu_src = 1'b1; id_imm = 32'd1;
    step();
    check("fwd_a mem result", ex_alu_result, 32'd8);
    check("fwd_a store rt", ex_store_data, 32'h0000_BEEF);
    set_op(3'b001, 32'h1111_0000, 32'h0000_0777);
    fwd_a = 2'b10; fwd_b = 2'b01; wb_fwd_data = 32'h20;
    step();
    check("fwd_b wb result", ex_alu_result, 32'h28);
    check("fwd_b wb store", ex_store_data, 32'h20);
    set_op(3'b010, 32'h100, 32'h1);
    fwd_a = 2'b11; fwd_b = 2'b11;
    step();
    check("fwd reserved result", ex_alu_result, 32'h101);
    check("fwd reserved store", ex_store_data, 32'h1);
    wb_fwd_data = '0;

    // Store with immediate: store data is rt, result is rs+imm.
    set_op(3'b010, 32'h1000, 32'hABCD);
    id_alu_src = 1'b1; id_imm = 32'h10; id_mem_write = 1'b1; id_reg_write = 1'b0;
    id_rd_addr = 5'd0;
    step();
    check("sw result", ex_alu_result, 32'h1010);
    check("sw store", ex_store_data, 32'hABCD);
    check("sw mem_write", ex_mem_write, 1);
    check("sw reg_write", ex_reg_write, 0);

    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      set_op(3'b001, 32'(i * 7 + 1), 32'h55);
      id_rd_addr = 5'(i + 9);
      step();
      check("stall result", ex_alu_result, 32'h1010);
      check("stall store", ex_store_data, 32'hABCD);
      check("stall mem_write", ex_mem_write, 1);
      check("stall reg_write", ex_reg_write, 0);
      check("stall rd", ex_rd_addr, 5'd0);
    end

    flush = 1'b1;
    step();
    check_all_zero("stall_flush");
    flush = 1'b0; stall = 1'b0;

    // Stall while forwarding from EX/MEM, then consume the held result.
    set_op(3'b010, 32'h40, 32'h2);
    step();
    check("hold base result", ex_alu_result, 32'h42);
    stall = 1'b1;
    set_op(3'b010, 32'h0, 32'h0);
    fwd_a = 2'b10; id_alu_src = 1'b1; id_imm = 32'h1;
    step();
    check("hold stalled result", ex_alu_result, 32'h42);
    stall = 1'b0;
    step();
    check("hold fwd result", ex_alu_result, 32'h43);
    check("hold fwd valid", ex_valid, 1);

    // Invalid slot carrying reg_write becomes a bubble.
    set_op(3'b010, 32'd1, 32'd2);
    id_valid = 1'b0; id_mem_read = 1'b1; id_mem_to_reg = 1'b1;
    step();
    check_all_zero("bubble");

    // Plain flush over a valid instruction.
    set_op(3'b010, 32'd6, 32'd6);
    flush = 1'b1;
    step();
    check_all_zero("flush");
    flush = 1'b0;

    // Asynchronous reset between edges.
    set_op(3'b010, 32'd1, 32'd1);
    id_mem_read = 1'b1; id_mem_to_reg = 1'b1;
    step();
    check("pre_reset result", ex_alu_result, 32'd2);
    check("pre_reset mem_to_reg", ex_mem_to_reg, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    step();
    check_all_zero("reset_held");
    rst_n = 1'b1;
    set_op(3'b010, 32'd4, 32'd4);
    step();
    check("post_reset result", ex_alu_result, 32'd8);
    check("post_reset valid", ex_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
